regfile_wb_sequencer: RTL and testbench

REGFILE_WB_SEQUENCER -- requirements
Module: regfile_wb_sequencer

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/regfile_wb_sequencer_if.sv | 27 ++
 rtl/wb_fwd_mux.sv | 40 ++++
 rtl/regfile_wb_sequencer.sv | 118 +++++++++++
 tb/tb_regfile_wb_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the writeback sequencer slice.
// Holds the register-ID and data widths, the RNONE/RRSP IDs, the sequencer
// state enum, the held-request struct, and two small helpers used by the RTL.
package y86_pkg;

    localparam int unsigned REG_W    = 4;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 15;

    typedef logic [REG_W-1:0]  reg_id_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RRSP  = 4'h4;

    typedef enum logic [1:0] {
        StIdle,
        StWrE,
        StWrM
    } wb_state_e;

    typedef struct packed {
        reg_id_t dst_e;
        reg_id_t dst_m;
        data_t   val_e;
        data_t   val_m;
    } wb_req_t;

    // First write state for a freshly accepted request.
    function automatic wb_state_e first_state(reg_id_t dst_e, reg_id_t dst_m);
        wb_state_e st;
        if (dst_e != RNONE) begin
            st = StWrE;
        end else if (dst_m != RNONE) begin
            st = StWrM;
        end else begin
            st = StIdle;
        end
        return st;
    endfunction

    // One-hot register mask; RNONE maps to all zeros.
    function automatic logic [NUM_REGS-1:0] reg_onehot(reg_id_t r);
        logic [NUM_REGS-1:0] m;
        for (int i = 0; i < NUM_REGS; i++) begin
            m[i] = (r == REG_W'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Writeback request channel between the pipeline (master) and the sequencer
// (slave).
//   wb_valid        : request offered
//   wb_ready        : sequencer accepts this cycle
//   wb_dstE/wb_dstM : destination register IDs (RNONE = no write)
//   wb_valE/wb_valM : writeback data
interface regfile_wb_sequencer_if;
    import y86_pkg::*;

    logic    wb_valid;
    logic    wb_ready;
    reg_id_t wb_dstE;
    reg_id_t wb_dstM;
    data_t   wb_valE;
    data_t   wb_valM;

    modport master (
        output wb_valid, wb_dstE, wb_dstM, wb_valE, wb_valM,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_dstE, wb_dstM, wb_valE, wb_valM,
        output wb_ready
    );

endinterface

// File: rtl/wb_fwd_mux.sv
// Hit detection and bypass select for one decode read port.
//   src        : decode read address
//   busy_mask  : registers with a pending write
//   pend_dst_m : held dstM of the in-flight request
//   val_e/val_m: held writeback data
//   fwd_en/fwd_data : bypass to decode
//   stall      : hit that cannot be satisfied by the bypass
// Build option: define WB_FWD_EN to enable bypassing; otherwise every hit stalls.
module wb_fwd_mux
    import y86_pkg::*;
(
    input  reg_id_t             src,
    input  logic [NUM_REGS-1:0] busy_mask,
    input  reg_id_t             pend_dst_m,
    input  data_t               val_e,
    input  data_t               val_m,
    output logic                fwd_en,
    output data_t               fwd_data,
    output logic                stall
);

`ifdef WB_FWD_EN
    localparam bit FwdEnable = 1'b1;
`else
    localparam bit FwdEnable = 1'b0;
`endif

    logic  hit;
    data_t sel_data;

    always_comb begin
        hit = |(busy_mask & reg_onehot(src));
        // dstM carries the final value when dstE == dstM.
        sel_data = (src == pend_dst_m) ? val_m : val_e;
        fwd_en   = hit & FwdEnable;
        fwd_data = fwd_en ? sel_data : '0;
        stall    = hit & ~fwd_en;
    end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Serialises a two-destination writeback request (dstE/valE, dstM/valM) onto
// the single register-file write port, E before M, tracking pending
// destinations for decode hazard stalls and optional bypass.
//   clk, reset            : clock, synchronous active-high reset
//   wb                    : writeback request channel (slave modport)
//   rf_we/rf_waddr/rf_wdata : register-file write port
//   rd_srcA/rd_srcB       : decode read addresses
//   busy_mask             : bit i = pending write to register i
//   rd_stall              : decode must hold
//   fwd_a_*/fwd_b_*       : bypass data per read port
// Build option: WB_FWD_EN enables bypassing (see wb_fwd_mux).
module regfile_wb_sequencer
    import y86_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_sequencer_if.slave  wb,
    output logic                   rf_we,
    output reg_id_t                rf_waddr,
    output data_t                  rf_wdata,
    input  reg_id_t                rd_srcA,
    input  reg_id_t                rd_srcB,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic                   rd_stall,
    output logic                   fwd_a_en,
    output data_t                  fwd_a_data,
    output logic                   fwd_b_en,
    output data_t                  fwd_b_data
);

    wb_state_e state_q, state_d;
    wb_req_t   hold_q, hold_d;
    logic      last_write;
    logic      accept;
    logic      stall_a, stall_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_write = (state_q == StWrM) ||
                     ((state_q == StWrE) && (hold_q.dst_m == RNONE));
        wb.wb_ready = ~reset && ((state_q == StIdle) || last_write);
        accept = wb.wb_valid && wb.wb_ready;

        // Accept is only possible when idle or finishing the last write.
        if (accept) begin
            hold_d  = '{dst_e: wb.wb_dstE, dst_m: wb.wb_dstM,
                        val_e: wb.wb_valE, val_m: wb.wb_valM};
            state_d = first_state(wb.wb_dstE, wb.wb_dstM);
        end else if (state_q == StWrE && hold_q.dst_m != RNONE) begin
            state_d = StWrM;
        end else begin
            state_d = StIdle;
        end

        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        busy_mask = '0;
        case (state_q)
            StWrE: begin
                rf_we     = 1'b1;
                rf_waddr  = hold_q.dst_e;
                rf_wdata  = hold_q.val_e;
                busy_mask = reg_onehot(hold_q.dst_e) | reg_onehot(hold_q.dst_m);
            end
            StWrM: begin
                rf_we     = 1'b1;
                rf_waddr  = hold_q.dst_m;
                rf_wdata  = hold_q.val_m;
                busy_mask = reg_onehot(hold_q.dst_m);
            end
            default: ;
        endcase

        // The in-flight write is discarded in the reset cycle itself.
        if (reset) begin
            rf_we    = 1'b0;
            rf_waddr = '0;
            rf_wdata = '0;
        end

        rd_stall = stall_a | stall_b;
    end

    wb_fwd_mux u_fwd_a (
        .src        (rd_srcA),
        .busy_mask  (busy_mask),
        .pend_dst_m (hold_q.dst_m),
        .val_e      (hold_q.val_e),
        .val_m      (hold_q.val_m),
        .fwd_en     (fwd_a_en),
        .fwd_data   (fwd_a_data),
        .stall      (stall_a)
    );

    wb_fwd_mux u_fwd_b (
        .src        (rd_srcB),
        .busy_mask  (busy_mask),
        .pend_dst_m (hold_q.dst_m),
        .val_e      (hold_q.val_e),
        .val_m      (hold_q.val_m),
        .fwd_en     (fwd_b_en),
        .fwd_data   (fwd_b_data),
        .stall      (stall_b)
    );

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed scenarios then randomized traffic,
// checked against a queue-of-pending-writes reference model.
module tb_regfile_wb_sequencer;

    logic        clk;
    logic        reset;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  rd_srcA, rd_srcB;
    logic [14:0] busy_mask;
    logic        rd_stall;
    logic        fwd_a_en, fwd_b_en;
    logic [63:0] fwd_a_data, fwd_b_data;

    regfile_wb_sequencer_if bus ();

    regfile_wb_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (bus),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rd_srcA    (rd_srcA),
        .rd_srcB    (rd_srcB),
        .busy_mask  (busy_mask),
        .rd_stall   (rd_stall),
        .fwd_a_en   (fwd_a_en),
        .fwd_a_data (fwd_a_data),
        .fwd_b_en   (fwd_b_en),
        .fwd_b_data (fwd_b_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of register writes still to be issued.
    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t  q[$];
    logic last_acc = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_fwd(input logic [3:0] src, output logic hit, output logic [63:0] data);
        hit  = 1'b0;
        data = '0;
        if (src != 4'hF) begin
            // Latest queued write to src is the value decode must see.
            foreach (q[i]) begin
                if (q[i].addr == src) begin
                    hit  = 1'b1;
                    data = q[i].data;
                end
            end
        end
    endtask

    // Drive inputs at the falling edge and check outputs against the model.
    task automatic apply(input logic rst, input logic v, input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] sa, input logic [3:0] sb);
        logic        hit_a, hit_b, exp_we;
        logic [63:0] dat_a, dat_b;
        logic [14:0] exp_busy;
        @(negedge clk);
        reset        = rst;
        bus.wb_valid = v;
        bus.wb_dstE  = de;
        bus.wb_dstM  = dm;
        bus.wb_valE  = ve;
        bus.wb_valM  = vm;
        rd_srcA      = sa;
        rd_srcB      = sb;
        #1;
        exp_busy = '0;
        foreach (q[i]) exp_busy[q[i].addr] = 1'b1;
        exp_we = !rst && (q.size() > 0);
        model_fwd(sa, hit_a, dat_a);
        model_fwd(sb, hit_b, dat_b);
        check_val("wb_ready", 64'(bus.wb_ready), 64'(!rst && (q.size() <= 1)));
        check_val("rf_we", 64'(rf_we), 64'(exp_we));
        check_val("rf_waddr", 64'(rf_waddr), exp_we ? 64'(q[0].addr) : 64'd0);
        check_val("rf_wdata", rf_wdata, exp_we ? q[0].data : 64'd0);
        check_val("busy_mask", 64'(busy_mask), 64'(exp_busy));
`ifdef WB_FWD_EN
        check_val("rd_stall", 64'(rd_stall), 64'd0);
        check_val("fwd_a_en", 64'(fwd_a_en), 64'(hit_a));
        check_val("fwd_a_data", fwd_a_data, dat_a);
        check_val("fwd_b_en", 64'(fwd_b_en), 64'(hit_b));
        check_val("fwd_b_data", fwd_b_data, dat_b);
`else
        check_val("rd_stall", 64'(rd_stall), 64'(hit_a | hit_b));
        check_val("fwd_a_en", 64'(fwd_a_en), 64'd0);
        check_val("fwd_a_data", fwd_a_data, 64'd0);
        check_val("fwd_b_en", 64'(fwd_b_en), 64'd0);
        check_val("fwd_b_data", fwd_b_data, 64'd0);
`endif
    endtask

    // Advance the model across the rising edge.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        last_acc = !reset && bus.wb_valid && (q.size() <= 1);
        if (reset) begin
            q.delete();
        end else begin
            if (q.size() > 0) q.delete(0);
            if (last_acc) begin
                if (bus.wb_dstE != 4'hF) begin
                    w.addr = bus.wb_dstE;
                    w.data = bus.wb_valE;
                    q.push_back(w);
                end
                if (bus.wb_dstM != 4'hF) begin
                    w.addr = bus.wb_dstM;
                    w.data = bus.wb_valM;
                    q.push_back(w);
                end
            end
        end
    endtask

    task automatic idle(input logic [3:0] sa);
        apply(1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, sa, 4'hF);
    endtask

    function automatic logic [3:0] rand_dst();
        logic [3:0] d;
        if ($urandom_range(0, 3) == 0) d = 4'hF;
        else d = 4'($urandom_range(0, 7));
        return d;
    endfunction

    logic        ov, r;
    logic [3:0]  ode, odm;
    logic [63:0] ove, ovm;

    initial begin
        reset = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_dstE = 4'hF;
        bus.wb_dstM = 4'hF;
        bus.wb_valE = '0;
        bus.wb_valM = '0;
        rd_srcA = 4'hF;
        rd_srcB = 4'hF;
        repeat (2) @(posedge clk);

        // Post-reset state.
        idle(4'h3);
        check_val("rst_ready", 64'(bus.wb_ready), 64'd1);
        check_val("rst_busy", 64'(busy_mask), 64'd0);
        tick();

        // Single E write.
        apply(1'b0, 1'b1, 4'h3, 4'hF, 64'h55, 64'h0, 4'hF, 4'hF); tick();
        idle(4'h3);
        check_val("e_only_we", 64'(rf_we), 64'd1);
        check_val("e_only_addr", 64'(rf_waddr), 64'd3);
        check_val("e_only_data", rf_wdata, 64'h55);
        check_val("e_only_busy", 64'(busy_mask), 64'h8);
        tick();
        idle(4'h3);
        check_val("e_only_busy_clr", 64'(busy_mask), 64'd0);
        tick();

        // dstE == dstM: E then M.
        apply(1'b0, 1'b1, 4'h4, 4'h4, 64'h100, 64'h200, 4'hF, 4'hF); tick();
        idle(4'h4);
        check_val("popq_e_data", rf_wdata, 64'h100);
        check_val("popq_e_ready", 64'(bus.wb_ready), 64'd0);
        tick();
        idle(4'h4);
        check_val("popq_m_addr", 64'(rf_waddr), 64'd4);
        check_val("popq_m_data", rf_wdata, 64'h200);
        tick();

        // No destinations.
        apply(1'b0, 1'b1, 4'hF, 4'hF, 64'h1, 64'h2, 4'hF, 4'hF); tick();
        idle(4'hF);
        check_val("none_we", 64'(rf_we), 64'd0);
        check_val("none_ready", 64'(bus.wb_ready), 64'd1);
        tick();

        // Back-to-back.
        apply(1'b0, 1'b1, 4'h1, 4'hF, 64'h11, 64'h0, 4'hF, 4'hF); tick();
        apply(1'b0, 1'b1, 4'h2, 4'hF, 64'h22, 64'h0, 4'hF, 4'hF);
        check_val("b2b_addr1", 64'(rf_waddr), 64'd1);
        tick();
        idle(4'hF);
        check_val("b2b_we2", 64'(rf_we), 64'd1);
        check_val("b2b_addr2", 64'(rf_waddr), 64'd2);
        tick();

        // Pending dstM hazard.
        apply(1'b0, 1'b1, 4'hF, 4'h7, 64'h0, 64'hABC, 4'hF, 4'hF); tick();
        idle(4'h7);
`ifdef WB_FWD_EN
        check_val("fwd_hit_en", 64'(fwd_a_en), 64'd1);
        check_val("fwd_hit_data", fwd_a_data, 64'hABC);
        check_val("fwd_hit_stall", 64'(rd_stall), 64'd0);
`else
        check_val("nofwd_stall", 64'(rd_stall), 64'd1);
`endif
        tick();

        // Reset during WR_E, with a competing request offered.
        apply(1'b0, 1'b1, 4'h5, 4'h6, 64'h5, 64'h6, 4'hF, 4'hF); tick();
        apply(1'b1, 1'b1, 4'h2, 4'h3, 64'h9, 64'hA, 4'hF, 4'hF);
        check_val("rst_cycle_we", 64'(rf_we), 64'd0);
        tick();
        idle(4'h6);
        check_val("rst_mid_busy", 64'(busy_mask), 64'd0);
        check_val("rst_mid_we", 64'(rf_we), 64'd0);
        tick();

        // Randomized traffic; an unaccepted offer is held unchanged.
        ov = 1'b0;
        ode = 4'hF; odm = 4'hF; ove = '0; ovm = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!ov || last_acc) begin
                ov  = ($urandom_range(0, 3) != 0);
                ode = rand_dst();
                odm = rand_dst();
                ove = {$urandom, $urandom};
                ovm = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 49) == 0);
            apply(r, ov, ode, odm, ove, ovm, rand_dst(), rand_dst());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
